// File: rtl/child_arb_pkg.sv
// Shared types and default sizing for the child round-robin arbiter.
package child_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam int N_REQ_DEF   = 5;
    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/child_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo N_REQ, returned as one-hot, index and an any flag.
module rr_pick
    import child_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDW   = $clog2(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDW-1:0]   win_idx,
    output logic             any
);

    logic [IDW-1:0] idx;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = IDW'((int'(ptr) + i) % N_REQ);
            if (!any && req[idx]) begin
                any          = 1'b1;
                win_oh[idx]  = 1'b1;
                win_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/child_rr_arbiter.sv
// Round-robin owner arbiter with IDLE/OWNED/GAP FSM and a one-cycle gap
// between owners. Define ARB_TIMEOUT_EN to enable forced release after TIMEOUT cycles.
module child_rr_arbiter
    import child_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     timeout,
    output logic                     busy
);

    localparam int IDW = $clog2(N_REQ);

    arb_state_e      state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] pick_oh;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             release_own;
    logic             expire;
    logic [IDW-1:0]   owner_nxt;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign release_own = done[gnt_id_q] | ~req[gnt_id_q];
    assign owner_nxt   = (gnt_id_q == IDW'(N_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    assign expire = (hold_cnt_q == CW'(TIMEOUT));

    // Counter reads 1 in the first OWNED cycle so expiry lands on cycle TIMEOUT.
    always_comb begin
        hold_cnt_d = '0;
        if (state_d == OWNED) begin
            hold_cnt_d = (state_q == OWNED) ? hold_cnt_q + CW'(1) : CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    logic unused_timeout_param;

    assign expire               = 1'b0;
    assign unused_timeout_param = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                gnt_d   = '0;
                state_d = IDLE;
                if (pick_any) begin
                    state_d  = OWNED;
                    gnt_d    = pick_oh;
                    gnt_id_d = pick_idx;
                end
            end
            OWNED: begin
                // A genuine release takes precedence over a coincident expiry.
                if (release_own || expire) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    ptr_d     = owner_nxt;
                    timeout_d = ~release_own;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_child_rr_arbiter.sv
// Directed scoreboard bench for child_rr_arbiter (N_REQ=5, TIMEOUT=16).
module tb_child_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;
    logic       timeout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int tmo_q[$];

    logic       prev_valid;
    logic [4:0] prev_gnt;

    child_rr_arbiter #(
        .N_REQ   (5),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation on every new grant and every timeout pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_gnt   = '0;
        end else begin
            if (gnt_valid && (!prev_valid || gnt != prev_gnt)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected actual gnt=%b expected none", gnt);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("grant_vec", 32'(gnt), 32'(1) << e);
                    chk("grant_id", 32'(gnt_id), 32'(e));
                end
            end
            if (timeout) begin
                if (tmo_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout_unexpected actual=1 expected=0 id=%0d", gnt_id);
                end else begin
                    int t;
                    t = tmo_q.pop_front();
                    chk("timeout_id", 32'(gnt_id), 32'(t));
                end
            end
            prev_valid = gnt_valid;
            prev_gnt   = gnt;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Single request: one-cycle latency, then withdraw -> GAP -> IDLE
        exp_q.push_back(2);
        req = 5'b00100;
        tick();
        chk("lat_gnt", 32'(gnt), 32'h04);
        chk("lat_id", 32'(gnt_id), 32'h2);
        chk("lat_busy", 32'(busy), 32'h1);
        req = 5'b00000;
        tick();
        chk("wd_gap_gnt", 32'(gnt), 32'h0);
        chk("wd_gap_busy", 32'(busy), 32'h1);
        tick();
        chk("wd_idle_busy", 32'(busy), 32'h0);

        // Reset to bring ptr back to 0, then full round robin with done pulses
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.push_back(0);
        req = 5'b11111;
        tick();
        chk("rr_first", 32'(gnt), 32'h01);
        for (int k = 0; k < 5; k++) begin
            int nxt;
            nxt = (k + 1) % 5;
            tick();
            tick();
            done = 5'(1 << k);
            tick();
            done = '0;
            chk("rr_gap_gnt", 32'(gnt), 32'h0);
            chk("rr_gap_busy", 32'(busy), 32'h1);
            exp_q.push_back(nxt);
            tick();
            chk("rr_next", 32'(gnt), 32'(1) << nxt);
        end

        // Non-owner done is ignored
        done = 5'b01000;
        tick();
        done = '0;
        chk("nonowner_done", 32'(gnt), 32'h01);
        tick();
        chk("nonowner_done2", 32'(gnt), 32'h01);

        // Asynchronous reset mid-OWNED
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_valid", 32'(gnt_valid), 32'h0);
        chk("arst_timeout", 32'(timeout), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        exp_q.push_back(0);
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h01);

        // Wrap-around: move ownership to 3, release into IDLE with ptr=4
        req = 5'b01000;
        exp_q.push_back(3);
        tick();
        chk("wrap_gap1", 32'(gnt), 32'h0);
        tick();
        chk("wrap_own3", 32'(gnt), 32'h08);
        req = 5'b00000;
        tick();
        chk("wrap_gap2", 32'(gnt), 32'h0);
        chk("hold_last_id", 32'(gnt_id), 32'h3);
        chk("hold_valid", 32'(gnt_valid), 32'h0);
        tick();
        chk("wrap_idle", 32'(busy), 32'h0);
        req = 5'b00001;
        exp_q.push_back(0);
        tick();
        chk("wrap_gnt", 32'(gnt), 32'h01);
        chk("wrap_id", 32'(gnt_id), 32'h0);

`ifdef ARB_TIMEOUT_EN
        // Forced release after 16 OWNED cycles; done on cycle 16 wins
        req = 5'b00000;
        tick();
        tick();
        req = 5'b00110;
        exp_q.push_back(1);
        tick();
        chk("to_own1", 32'(gnt), 32'h02);
        repeat (15) tick();
        chk("to_cycle16", 32'(gnt), 32'h02);
        tmo_q.push_back(1);
        exp_q.push_back(2);
        tick();
        chk("to_gap_gnt", 32'(gnt), 32'h0);
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_id", 32'(gnt_id), 32'h1);
        tick();
        chk("to_next_gnt", 32'(gnt), 32'h04);
        chk("to_pulse_end", 32'(timeout), 32'h0);
        req = 5'b00100;
        repeat (15) tick();
        done = 5'b00100;
        req  = 5'b00000;
        tick();
        done = '0;
        chk("done16_gnt", 32'(gnt), 32'h0);
        chk("done16_no_to", 32'(timeout), 32'h0);
`else
        // Ownership is unbounded without the timeout feature
        repeat (20) tick();
        chk("long_own_gnt", 32'(gnt), 32'h01);
        chk("long_own_to", 32'(timeout), 32'h0);
        req = 5'b00000;
`endif

        repeat (3) tick();
        chk("end_idle", 32'(busy), 32'h0);
        chk("grants_left", 32'(exp_q.size()), 32'h0);
        chk("timeouts_left", 32'(tmo_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
